scalu_pipe: RTL and testbench
=============================

# scalu_pipe

Parametrised successor to the single-cycle scalar ALU. It accepts ops from the execute reservation station (exers), evaluates them through a configurable-depth result pipeline, and buffers completed results in an output queue toward writeback (wb). Because the queue absorbs writeback backpressure, `wb_scalu_stall` never propagates combinationally to `scalu_stall`. Issue is credit-gated so the queue can never overflow.

## Interface
Parameters:
- `XLEN`, 32: operand/result width
- `OP_W`, 5: ALU op field width
- `ROBID_W`, 7: ROB id width
- `RD_W`, 6: destination register tag width
- `LAT`, 1: register stages from input register to queue write, ≥1 (1 = input register only)
- `QDEPTH`, 4: output queue entries; also the credit limit; must be ≥ `LAT`+1

Ports:
- `clk` in 1: clock; all state on rising edge
- `rst` in 1: reset, synchronous, active-low (0 = reset)
- `exers_scalu_issue` in 1: op valid
- `exers_scalu_op` in OP_W: ALU op
- `exers_robid` in ROBID_W: ROB id
- `exers_rd` in RD_W: destination tag
- `exers_op1`, `exers_op2` in XLEN: operands
- `scalu_stall` out 1: issue not accepted this cycle
- `scalu_valid` out 1: queue head valid
- `scalu_error` out 1: constant 0
- `scalu_ecause` out 5: constant 0
- `scalu_robid` out ROBID_W, `scalu_rd` out RD_W, `scalu_result` out XLEN: queue head fields
- `wb_scalu_stall` in 1: wb cannot take the head this cycle
- `rob_flush` in 1: discard all work
- `scalu_busy` out 1: any op in flight or queued

## Operation
- `accept` = `exers_scalu_issue` & ~`scalu_stall`. `pop` = `scalu_valid` & ~`wb_scalu_stall`.
- Credit counter `cnt` (0..QDEPTH) counts ops in the input register, the pipe stages, and the queue.
- `cnt` next = `cnt` + `accept` − `pop`.
- `scalu_stall` = (`cnt` == QDEPTH). It is a function of registered state only.
- A pop in the same cycle does not free a credit for an issue in that cycle.
- Input register captures op/robid/rd/op1/op2 on `accept`. Stage valid bits shift every cycle; the pipe never stalls.
- The ALU (combinational, existing `alu_simple`) evaluates on input-register contents. Stages 2..LAT carry {robid, rd, result}.
- The final stage writes into the queue when valid. Credits guarantee free space, so queue-full on write is unreachable; flag it as an assertion.
- Queue is FIFO and circular. Read and write pointers wrap at QDEPTH, so QDEPTH need not be a power of two. Simultaneous read and write at any occupancy is legal.
- Head data is stable while `scalu_valid` & `wb_scalu_stall`.
- `scalu_busy` = (`cnt` != 0).
- Flush: `rob_flush` or reset has the following effect:
  - clears all stage valids, queue pointers/occupancy, and `cnt` at the next edge;
  - overrides any `accept`/`pop` in the same cycle;
  - any issue presented in the flush cycle is dropped.
- Reset values:
  - `scalu_valid` = 0, `scalu_stall` = 0, `scalu_busy` = 0
  - `scalu_error`/`scalu_ecause` = 0
  - data outputs don't-care; payload registers are not reset.

## Timing
- Issue accepted at end of cycle t. Result visible at `scalu_valid` in cycle t+LAT+1 (empty queue, no stall).
  - LAT=1: 2 cycles.
- Throughput: 1 op/cycle sustained while `wb_scalu_stall`=0, given QDEPTH ≥ LAT+1.
- Under a continuous `wb_scalu_stall`, exactly QDEPTH ops are accepted, then `scalu_stall`=1.
- After `wb_scalu_stall` deasserts, `scalu_stall` drops the cycle after the first pop.
- Flush asserted in cycle f: `scalu_valid`=0, `cnt`=0, `scalu_stall`=0 in cycle f+1. An issue in f+1 is accepted normally.
- Reset released at end of cycle r: an issue in r+1 is accepted.

## Structure
- `scalu_pkg` holds:
  - the ALU op encoding constants shared with exers and `alu_simple`;
  - a packed result-entry typedef {robid, rd, result};
  - the `scalu_ecause` width constant.
- Sub-module `scalu_outq` is the parametrised circular FIFO (depth QDEPTH, entry = result typedef). It has push/pop, head data, empty/count outputs, and its own synchronous active-low clear (driven by reset | flush).
- The top level holds the input register, stage shift chain, credit counter, and an `alu_simple` instance.

## Test plan
- Single ADD: op1=5, op2=7, robid=3, rd=9, LAT=1, wb idle. Issue in cycle 0 → `scalu_valid`=1 in cycle 2 only, with result=12, robid=3, rd=9.
- Back-to-back: 8 issues of ADD i+i (i=0..7), wb idle. `scalu_stall` never asserts; results 0,2,…,14 appear in order on consecutive cycles.
- Backpressure, QDEPTH=4, LAT=2, `wb_scalu_stall`=1 throughout:
  - issue continuously; accepts stop after 4 and `scalu_stall`=1;
  - release wb: 4 results drain in order, stall drops one cycle after the first pop, no loss or duplication.
- Flush mid-pipe: with 3 ops queued and 1 in stage 1, assert `rob_flush` with a simultaneous issue. Next cycle `scalu_valid`=0, `scalu_busy`=0, `scalu_stall`=0; the flushed ops never appear.
- Pointer wrap, QDEPTH=3 (non-power-of-2): random `wb_scalu_stall` over 200 issues. Scoreboard: in-order results, `cnt` never exceeds 3, no queue-full assertion fires.
- Reset mid-operation: drive `rst`=0 for 1 cycle while the queue is full. All outputs return to reset values next cycle; the first post-reset issue completes with correct latency.

Source files
------------

// File: rtl/scalu_pkg.sv
// Shared scalar ALU definitions: op encodings, result-entry layout and
// exception-cause width used by exers, alu_simple, scalu_pipe and scalu_outq.
package scalu_pkg;

    localparam int ECAUSE_W = 5;

    localparam int XLEN_DEF  = 32;
    localparam int ROBID_DEF = 7;
    localparam int RD_DEF    = 6;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLL  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_SLT  = 5'd8;
    localparam logic [4:0] ALU_SLTU = 5'd9;
    localparam logic [4:0] ALU_PASS = 5'd10;

    // Completed-op entry as held in the output queue.
    typedef struct packed {
        logic [ROBID_DEF-1:0] robid;
        logic [RD_DEF-1:0]    rd;
        logic [XLEN_DEF-1:0]  result;
    } scalu_ent_t;

endpackage

// File: rtl/alu_simple.sv
// Combinational scalar ALU.
// Ports: op (ALU op), a/b (operands), y (result).
module alu_simple
    import scalu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] y
);

    localparam int SW = $clog2(XLEN);

    logic [SW-1:0] sh;

    assign sh = b[SW-1:0];

    always_comb begin
        y = '0;
        case (op)
            OP_W'(ALU_ADD):  y = a + b;
            OP_W'(ALU_SUB):  y = a - b;
            OP_W'(ALU_AND):  y = a & b;
            OP_W'(ALU_OR):   y = a | b;
            OP_W'(ALU_XOR):  y = a ^ b;
            OP_W'(ALU_SLL):  y = a << sh;
            OP_W'(ALU_SRL):  y = a >> sh;
            OP_W'(ALU_SRA):  y = $signed(a) >>> sh;
            OP_W'(ALU_SLT):  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_W'(ALU_SLTU): y = {{(XLEN-1){1'b0}}, a < b};
            OP_W'(ALU_PASS): y = b;
            default:         y = '0;
        endcase
    end

endmodule

// File: rtl/scalu_outq.sv
// Circular result FIFO; pointers wrap at DEPTH so any depth >= 2 works.
// Ports: clk, clr_n (sync active-low clear), push/push_data, pop, head, empty, count.
module scalu_outq
    import scalu_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = scalu_ent_t,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] rp;
    logic [PW-1:0] wp;
    logic          full;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign head  = mem[rp];

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            rp    <= '0;
            wp    <= '0;
            count <= '0;
        end else begin
            if (push) wp <= inc(wp);
            if (pop)  rp <= inc(rp);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= push_data;
    end

    // Upstream credits reserve a slot for every op in flight.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!clr_n) !(push && full)
    );

endmodule

// File: rtl/scalu_pipe.sv
// Pipelined scalar ALU: input register, LAT-1 result stages, output queue, credit-gated issue.
// Ports: exers_* issue side, scalu_* result/status side, wb_scalu_stall, rob_flush, clk, rst (sync, active-low).
module scalu_pipe
    import scalu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int OP_W    = 5,
    parameter int ROBID_W = 7,
    parameter int RD_W    = 6,
    parameter int LAT     = 1,
    parameter int QDEPTH  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exers_scalu_issue,
    input  logic [OP_W-1:0]     exers_scalu_op,
    input  logic [ROBID_W-1:0]  exers_robid,
    input  logic [RD_W-1:0]     exers_rd,
    input  logic [XLEN-1:0]     exers_op1,
    input  logic [XLEN-1:0]     exers_op2,
    output logic                scalu_stall,
    output logic                scalu_valid,
    output logic                scalu_error,
    output logic [ECAUSE_W-1:0] scalu_ecause,
    output logic [ROBID_W-1:0]  scalu_robid,
    output logic [RD_W-1:0]     scalu_rd,
    output logic [XLEN-1:0]     scalu_result,
    input  logic                wb_scalu_stall,
    input  logic                rob_flush,
    output logic                scalu_busy
);

    localparam int CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic [XLEN-1:0]    result;
    } ent_t;

    logic               flush_n;
    logic               accept;
    logic               pop;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      q_cnt;
    logic               q_empty;

    logic               in_v;
    logic [OP_W-1:0]    in_op;
    logic [ROBID_W-1:0] in_robid;
    logic [RD_W-1:0]    in_rd;
    logic [XLEN-1:0]    in_op1;
    logic [XLEN-1:0]    in_op2;
    logic [XLEN-1:0]    alu_y;

    ent_t               ent0;
    ent_t               push_d;
    ent_t               head;
    logic               push;

    // Reset and flush share one synchronous clear.
    assign flush_n = rst & ~rob_flush;

    // Stall depends only on the credit register, never on wb backpressure.
    assign scalu_stall  = (cnt == CW'(QDEPTH));
    assign accept       = exers_scalu_issue & ~scalu_stall;
    assign scalu_valid  = ~q_empty;
    assign pop          = scalu_valid & ~wb_scalu_stall;
    assign scalu_busy   = (cnt != '0);
    assign scalu_error  = 1'b0;
    assign scalu_ecause = '0;
    assign scalu_robid  = head.robid;
    assign scalu_rd     = head.rd;
    assign scalu_result = head.result;

    always_ff @(posedge clk) begin
        if (!flush_n) begin
            cnt  <= '0;
            in_v <= 1'b0;
        end else begin
            cnt  <= cnt + CW'(accept) - CW'(pop);
            in_v <= accept;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            in_op    <= exers_scalu_op;
            in_robid <= exers_robid;
            in_rd    <= exers_rd;
            in_op1   <= exers_op1;
            in_op2   <= exers_op2;
        end
    end

    alu_simple #(
        .XLEN (XLEN),
        .OP_W (OP_W)
    ) u_alu (
        .op (in_op),
        .a  (in_op1),
        .b  (in_op2),
        .y  (alu_y)
    );

    assign ent0 = '{robid: in_robid, rd: in_rd, result: alu_y};

    if (LAT > 1) begin : g_stages
        logic [LAT-2:0] sv;
        ent_t           sd [LAT-1];

        always_ff @(posedge clk) begin
            if (!flush_n) begin
                sv <= '0;
            end else begin
                sv[0] <= in_v;
                for (int k = 1; k < LAT - 1; k++) sv[k] <= sv[k-1];
            end
        end

        always_ff @(posedge clk) begin
            sd[0] <= ent0;
            for (int k = 1; k < LAT - 1; k++) sd[k] <= sd[k-1];
        end

        assign push   = sv[LAT-2];
        assign push_d = sd[LAT-2];
    end else begin : g_direct
        assign push   = in_v;
        assign push_d = ent0;
    end

    scalu_outq #(
        .DEPTH (QDEPTH),
        .T     (ent_t)
    ) u_outq (
        .clk       (clk),
        .clr_n     (flush_n),
        .push      (push),
        .push_data (push_d),
        .pop       (pop),
        .head      (head),
        .empty     (q_empty),
        .count     (q_cnt)
    );

    // Queue occupancy is a subset of the credits in use.
    a_q_le_cnt: assert property (
        @(posedge clk) disable iff (!flush_n) q_cnt <= cnt
    );

endmodule

// File: tb/tb_scalu_pipe.sv
// Directed bench for scalu_pipe on three configurations sharing the issue bus:
// u0 LAT=1/QDEPTH=4, u1 LAT=2/QDEPTH=4, u2 LAT=1/QDEPTH=3.
module tb_scalu_pipe;
    import scalu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        issue;
    logic        flush;
    logic [4:0]  op;
    logic [6:0]  robid;
    logic [5:0]  rd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  wb;
    logic [2:0]  stall;
    logic [2:0]  valid;
    logic [2:0]  err;
    logic [2:0]  busy;
    logic [4:0]  ecause  [3];
    logic [6:0]  o_robid [3];
    logic [5:0]  o_rd    [3];
    logic [31:0] res     [3];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        scalu_pipe #(
            .LAT    ((g == 1) ? 2 : 1),
            .QDEPTH ((g == 2) ? 3 : 4)
        ) u_dut (
            .clk               (clk),
            .rst               (rst),
            .exers_scalu_issue (issue),
            .exers_scalu_op    (op),
            .exers_robid       (robid),
            .exers_rd          (rd),
            .exers_op1         (op1),
            .exers_op2         (op2),
            .scalu_stall       (stall[g]),
            .scalu_valid       (valid[g]),
            .scalu_error       (err[g]),
            .scalu_ecause      (ecause[g]),
            .scalu_robid       (o_robid[g]),
            .scalu_rd          (o_rd[g]),
            .scalu_result      (res[g]),
            .wb_scalu_stall    (wb[g]),
            .rob_flush         (flush),
            .scalu_busy        (busy[g])
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int r,
                         input logic [31:0] a, input logic [31:0] b);
        issue = v;
        op    = ALU_ADD;
        robid = 7'(r);
        rd    = 6'(r);
        op1   = a;
        op2   = b;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        flush = 1'b0;
        issue = 1'b0;
        wb    = '0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        flush = 1'b0;
        wb    = '0;
        drive(1'b1, 1, 1, 1);
        step();
        rst   = 1'b1;
        issue = 1'b0;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (valid[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_valid[%0d] got=%b exp=0", g, valid[g]);
            end
            checks++;
            if (stall[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_stall[%0d] got=%b exp=0", g, stall[g]);
            end
            checks++;
            if (busy[g] !== 1'b0) begin
                failures++;
                $display("FAIL reset_busy[%0d] got=%b exp=0", g, busy[g]);
            end
            checks++;
            if (err[g] !== 1'b0 || ecause[g] !== 5'd0) begin
                failures++;
                $display("FAIL reset_error[%0d] got=%b/%0d exp=0/0",
                         g, err[g], ecause[g]);
            end
        end
        step();
        checks++;
        if (busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop_issue got_busy=%b exp=0", busy[0]);
        end
    endtask

    task automatic test_single_add();
        do_reset();
        drive(1'b1, 3, 5, 7);
        rd = 6'd9;
        step();
        issue = 1'b0;
        checks++;
        if (valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL add_early_valid got=%b exp=0", valid[0]);
        end
        step();
        checks++;
        if (valid[0] !== 1'b1) begin
            failures++;
            $display("FAIL add_valid got=%b exp=1", valid[0]);
        end
        checks++;
        if (res[0] !== 32'd12) begin
            failures++;
            $display("FAIL add_result got=%0d exp=12", res[0]);
        end
        checks++;
        if (o_robid[0] !== 7'd3 || o_rd[0] !== 6'd9) begin
            failures++;
            $display("FAIL add_tags got=%0d/%0d exp=3/9", o_robid[0], o_rd[0]);
        end
        step();
        checks++;
        if (valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL add_late_valid got=%b exp=0", valid[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(1'b1, c, c, c);
            else issue = 1'b0;
            checks++;
            if (stall[0] !== 1'b0) begin
                failures++;
                $display("FAIL b2b_stall cyc=%0d got=%b exp=0", c, stall[0]);
            end
            if (c >= 2 && c < 10) begin
                checks++;
                if (valid[0] !== 1'b1 || res[0] !== 32'(2 * (c - 2))) begin
                    failures++;
                    $display("FAIL b2b_result cyc=%0d got=%b/%0d exp=1/%0d",
                             c, valid[0], res[0], 2 * (c - 2));
                end
            end else if (c >= 10) begin
                checks++;
                if (valid[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_extra cyc=%0d got=%b exp=0", c, valid[0]);
                end
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int pops;
        int expq[$];
        int e;
        do_reset();
        acc   = 0;
        pops  = 0;
        wb[1] = 1'b1;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 10 + c, c, 100);
            if (!stall[1]) begin
                acc++;
                expq.push_back(10 + c);
            end
            step();
        end
        issue = 1'b0;
        checks++;
        if (acc != 4) begin
            failures++;
            $display("FAIL bp_accepts got=%0d exp=4", acc);
        end
        checks++;
        if (stall[1] !== 1'b1) begin
            failures++;
            $display("FAIL bp_stall got=%b exp=1", stall[1]);
        end
        wb[1] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                checks++;
                if (stall[1] !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_stall_drop got=%b exp=0", stall[1]);
                end
            end
            if (valid[1]) begin
                pops++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL bp_dup robid=%0d exp=none", o_robid[1]);
                end else begin
                    e = expq.pop_front();
                    if (o_robid[1] !== 7'(e) || res[1] !== 32'(e - 10 + 100)) begin
                        failures++;
                        $display("FAIL bp_order got=%0d/%0d exp=%0d/%0d",
                                 o_robid[1], res[1], e, e - 10 + 100);
                    end
                end
            end
            step();
        end
        checks++;
        if (pops != 4) begin
            failures++;
            $display("FAIL bp_pops got=%0d exp=4", pops);
        end
    endtask

    task automatic test_flush();
        int seen;
        do_reset();
        seen  = 0;
        wb[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 20 + i, i, i);
            step();
        end
        checks++;
        if (valid[0] !== 1'b1 || stall[0] !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre got=%b/%b exp=1/1", valid[0], stall[0]);
        end
        drive(1'b1, 30, 9, 9);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wb[0] = 1'b0;
        drive(1'b1, 40, 1, 2);
        checks++;
        if (valid[0] !== 1'b0 || busy[0] !== 1'b0 || stall[0] !== 1'b0) begin
            failures++;
            $display("FAIL flush_clear got=%b/%b/%b exp=0/0/0",
                     valid[0], busy[0], stall[0]);
        end
        step();
        issue = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (valid[0]) begin
                checks++;
                if (o_robid[0] !== 7'd40 || res[0] !== 32'd3 || c != 1) begin
                    failures++;
                    $display("FAIL flush_leak cyc=%0d got=%0d/%0d exp=40/3@1",
                             c, o_robid[0], res[0]);
                end
                seen++;
            end
            step();
        end
        checks++;
        if (seen != 1) begin
            failures++;
            $display("FAIL flush_post_issue got=%0d exp=1", seen);
        end
    endtask

    task automatic test_wrap();
        int n;
        int k;
        int mcnt;
        int cyc;
        int acc;
        int pp;
        do_reset();
        n    = 0;
        k    = 0;
        mcnt = 0;
        cyc  = 0;
        while (k < 200 && cyc < 3000) begin
            wb[2] = 1'($urandom_range(0, 1));
            if (n < 200) drive(1'b1, n, 32'(3 * n), 32'(n));
            else issue = 1'b0;
            checks++;
            if (stall[2] !== (mcnt == 3)) begin
                failures++;
                $display("FAIL wrap_stall cyc=%0d got=%b exp=%b",
                         cyc, stall[2], mcnt == 3);
            end
            checks++;
            if (busy[2] !== (mcnt != 0)) begin
                failures++;
                $display("FAIL wrap_busy cyc=%0d got=%b exp=%b",
                         cyc, busy[2], mcnt != 0);
            end
            acc = (issue && !stall[2]) ? 1 : 0;
            pp  = (valid[2] && !wb[2]) ? 1 : 0;
            if (pp == 1) begin
                checks++;
                if (res[2] !== 32'(4 * k) || o_robid[2] !== 7'(k)) begin
                    failures++;
                    $display("FAIL wrap_order k=%0d got=%0d/%0d exp=%0d/%0d",
                             k, o_robid[2], res[2], k % 128, 4 * k);
                end
                k++;
            end
            if (acc == 1) n++;
            mcnt = mcnt + acc - pp;
            step();
            cyc++;
        end
        issue = 1'b0;
        wb[2] = 1'b0;
        checks++;
        if (k != 200) begin
            failures++;
            $display("FAIL wrap_timeout got=%0d exp=200", k);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 60 + i, i, i);
            step();
        end
        issue = 1'b0;
        step();
        step();
        checks++;
        if (valid[0] !== 1'b1 || stall[0] !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got=%b/%b exp=1/1", valid[0], stall[0]);
        end
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (valid[0] !== 1'b0 || stall[0] !== 1'b0 || busy[0] !== 1'b0 ||
            err[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear got=%b/%b/%b/%b exp=0/0/0/0",
                     valid[0], stall[0], busy[0], err[0]);
        end
        wb[0] = 1'b0;
        drive(1'b1, 77, 20, 22);
        step();
        issue = 1'b0;
        checks++;
        if (valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_early got=%b exp=0", valid[0]);
        end
        step();
        checks++;
        if (valid[0] !== 1'b1 || res[0] !== 32'd42 || o_robid[0] !== 7'd77) begin
            failures++;
            $display("FAIL rstmid_result got=%b/%0d/%0d exp=1/42/77",
                     valid[0], res[0], o_robid[0]);
        end
    endtask

    initial begin
        rst   = 1'b0;
        flush = 1'b0;
        issue = 1'b0;
        wb    = '0;
        op    = '0;
        robid = '0;
        rd    = '0;
        op1   = '0;
        op2   = '0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
